alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester round-robin arbiter and sequencer that time-shares the single ALUControl + ALU pair. Each requester presents an ALUOp/function/operand bundle with a request; the block accepts one bundle per cycle, drives the shared ALU from registered operands, captures the result, and returns it to the granted requester with a done pulse. It sits between the core's execute stage and a secondary requester such as a multiply/address helper.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req_0, req_1  in  1  request; held high until the matching gnt
- op_0, op_1  in  3  ALUOp code (R-type 3'b111, ADDI 3'b100, ORI 3'b101)
- funct_0, funct_1  in  6  function field (meaningful for R-type)
- a_0, b_0, a_1, b_1  in  DATA_WIDTH  operands
- shamt_0, shamt_1  in  5  shift amount
- gnt_0, gnt_1  out  1  one-cycle acceptance pulse
- done_0, done_1  out  1  one-cycle result-valid pulse
- result  out  DATA_WIDTH  captured ALU result, valid while any done is high
- zero  out  1  captured ALU zero flag
- busy  out  1  high in EXEC and DONE
- alu_op  out  3  to ALUControl ALUOp
- alu_function  out  6  to ALUControl ALUFunction
- alu_a, alu_b  out  DATA_WIDTH  to ALU operands
- alu_shamt  out  5  to ALU shift amount
- alu_result  in  DATA_WIDTH  from ALU (combinational path)
- alu_zero  in  1  from ALU

## Operation
- States: IDLE, EXEC, DONE.
- Requests are sampled only at edges where state is IDLE or DONE; they are ignored in EXEC.
- Pick rule:
  - only one req high: that port wins.
  - both high: the port not in last_grant wins.
  - last_grant is updated on every pick.
- On a pick: latch op/funct/a/b/shamt of the winner into issue registers; record the owner; go to EXEC.
- With no request: IDLE stays IDLE; DONE returns to IDLE.
- EXEC:
  - gnt_owner=1.
  - alu_* outputs driven from the issue registers.
  - At the end of the cycle, capture alu_result/alu_zero into result/zero; go to DONE.
- DONE:
  - done_owner=1; result/zero hold the captured values.
  - Performs the pick rule in the same edge, giving back-to-back issue.
- Requester obligations:
  - drop req by the DONE cycle unless a further op is intended.
  - req withdrawn before a pick is legal; no gnt is issued.
- Op codes outside {100,101,111} are issued unchanged; ALUControl's default handles them. No error flag.
- alu_* outputs hold the last issued values outside EXEC, so there is no ALU toggling while idle.
- result/zero hold until the next capture.

## Timing
- Reset (reset=0 at an edge) values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - All gnt/done/busy=0.
  - result=0, zero=0, all alu_* outputs=0, issue registers=0.
- Reset mid-operation aborts the op: no gnt or done pulse is emitted after reset, and the captured result is discarded.
- Latency: req sampled at edge k → gnt in cycle k+1 → done/result in cycle k+2.
- Throughput: one op per 2 cycles under continuous requests.
- Fairness: with both req held continuously, grants alternate 0,1,0,1…
- ALU path: the issue register feeds the ALU, which feeds the result register within one cycle. ALUControl + ALU must close timing in one clk period.
- gnt and done are never high for both ports in the same cycle. gnt_x and done_x for the same op are in consecutive cycles.

## Structure
- Shared package `mips_alu_pkg`:
  - ALUOp constants ALUOP_RTYPE=3'b111, ALUOP_ADDI=3'b100, ALUOP_ORI=3'b101.
  - R-type funct constants AND=6'b100100, OR=6'b100101, NOR=6'b100111, ADD=6'b100000.
  - State encoding IDLE/EXEC/DONE.
- One sub-module `rr_pick2`:
  - Combinational two-way pick from req_0, req_1, last_grant.
  - Outputs winner and valid.
- FSM, issue registers and capture registers live in the top module.

## Test plan
- Single R-type AND: port 0 req, op=111, funct=100100, a=0xF0F0_F0F0, b=0x0FF0_0FF0 → gnt_0 at k+1, done_0 at k+2, result=0x00F0_00F0, zero=0.
- Tie after reset: both req in the same cycle, port 0 ADDI a=5 b=3, port 1 ORI a=0x10 b=0x01 → grants in order 0 then 1, results 8 then 0x11, done pulses 2 cycles apart.
- Fairness: both req held for 8 ops → grant sequence 0,1,0,1,0,1,0,1; busy stays high throughout; no idle cycle between ops.
- Zero flag: port 1 R-type ADD, a=0xFFFF_FFFF, b=1 → result=0, zero=1, done_1 only.
- Reset mid-op: reset=0 during the EXEC cycle → next cycle all outputs at reset values, no done pulse; the following tie goes to port 0.
- Withdrawn request: req_1 pulses for one cycle while state=EXEC (port 0 op) → request ignored, gnt_1 never asserted, state returns to IDLE after done_0.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared ALU-side definitions: ALUOp codes, R-type funct codes and the
// sequencer state encoding used by alu_share_arbiter.
package mips_alu_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADDI  = 3'b100;
    localparam logic [2:0] ALUOP_ORI   = 3'b101;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_pick2 (
    input  logic i_req_0,
    input  logic i_req_1,
    input  logic i_last_grant,
    output logic o_winner,
    output logic o_valid
);

    assign o_valid = i_req_0 | i_req_1;

    always_comb begin
        o_winner = 1'b0;
        if (i_req_0 && i_req_1) begin
            o_winner = ~i_last_grant;
        end else if (i_req_1) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALUControl + ALU pair between two requesters. A pick in
// IDLE or DONE issues the winner's bundle; EXEC drives the ALU; DONE returns it.
module alu_share_arbiter
    import mips_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  req_1,
    input  logic [2:0]            op_0,
    input  logic [2:0]            op_1,
    input  logic [5:0]            funct_0,
    input  logic [5:0]            funct_1,
    input  logic [DATA_WIDTH-1:0] a_0,
    input  logic [DATA_WIDTH-1:0] b_0,
    input  logic [DATA_WIDTH-1:0] a_1,
    input  logic [DATA_WIDTH-1:0] b_1,
    input  logic [4:0]            shamt_0,
    input  logic [4:0]            shamt_1,
    output logic                  gnt_0,
    output logic                  gnt_1,
    output logic                  done_0,
    output logic                  done_1,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  busy,
    output logic [2:0]            alu_op,
    output logic [5:0]            alu_function,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            alu_shamt,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic [1:0]            dbg_state
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_grant;
    logic                  r_owner;
    logic [2:0]            r_op;
    logic [5:0]            r_funct;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [4:0]            r_shamt;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;

    logic w_winner;
    logic w_valid;
    logic w_pick;

    rr_pick2 u_pick (
        .i_req_0      (req_0),
        .i_req_1      (req_1),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    // Requests are only looked at when the ALU slot is free this edge.
    assign w_pick = (r_state != EXEC) && w_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick) w_state_next = EXEC;
            EXEC:    w_state_next = DONE;
            DONE:    w_state_next = w_pick ? EXEC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= '0;
            r_funct      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_shamt      <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pick) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_op         <= w_winner ? op_1    : op_0;
                r_funct      <= w_winner ? funct_1 : funct_0;
                r_a          <= w_winner ? a_1     : a_0;
                r_b          <= w_winner ? b_1     : b_0;
                r_shamt      <= w_winner ? shamt_1 : shamt_0;
            end
            if (r_state == EXEC) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

    always_comb begin
        gnt_0  = 1'b0;
        gnt_1  = 1'b0;
        done_0 = 1'b0;
        done_1 = 1'b0;
        busy   = 1'b0;
        case (r_state)
            EXEC: begin
                gnt_0 = ~r_owner;
                gnt_1 = r_owner;
                busy  = 1'b1;
            end
            DONE: begin
                done_0 = ~r_owner;
                done_1 = r_owner;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    // Issue registers feed the ALU directly, so it stays quiet between ops.
    assign alu_op       = r_op;
    assign alu_function = r_funct;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_shamt    = r_shamt;
    assign result       = r_result;
    assign zero         = r_zero;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU stub.
module tb_alu_share_arbiter;
    import mips_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_0, req_1;
    logic [2:0]   op_0, op_1;
    logic [5:0]   funct_0, funct_1;
    logic [W-1:0] a_0, b_0, a_1, b_1;
    logic [4:0]   shamt_0, shamt_1;
    logic         gnt_0, gnt_1, done_0, done_1;
    logic [W-1:0] result;
    logic         zero, busy;
    logic [2:0]   alu_op;
    logic [5:0]   alu_function;
    logic [W-1:0] alu_a, alu_b;
    logic [4:0]   alu_shamt;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    alu_share_arbiter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .req_1(req_1),
        .op_0(op_0), .op_1(op_1),
        .funct_0(funct_0), .funct_1(funct_1),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
        .shamt_0(shamt_0), .shamt_1(shamt_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .result(result), .zero(zero), .busy(busy),
        .alu_op(alu_op), .alu_function(alu_function),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .dbg_state(dbg_state)
    );

    // clock / ALU stub
    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALUOP_ADDI: alu_result = alu_a + alu_b;
            ALUOP_ORI:  alu_result = alu_a | alu_b;
            ALUOP_RTYPE: begin
                case (alu_function)
                    FUNCT_AND: alu_result = alu_a & alu_b;
                    FUNCT_OR:  alu_result = alu_a | alu_b;
                    FUNCT_NOR: alu_result = ~(alu_a | alu_b);
                    FUNCT_ADD: alu_result = alu_a + alu_b;
                    default:   alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input bit p, input logic [2:0] op, input logic [5:0] fn,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        if (!p) begin
            req_0 = 1'b1; op_0 = op; funct_0 = fn; a_0 = a; b_0 = b; shamt_0 = 5'd0;
        end else begin
            req_1 = 1'b1; op_1 = op; funct_1 = fn; a_1 = a; b_1 = b; shamt_1 = 5'd0;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},   {30'd0, gnt_1, gnt_0}, 32'd0);
        chk({tag, "_done"},  {30'd0, done_1, done_0}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
    endtask

    typedef struct {
        bit           port;
        logic [2:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, ALUOP_RTYPE, FUNCT_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        vecs[1] = '{1'b1, ALUOP_RTYPE, FUNCT_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b0, ALUOP_ADDI,  6'd0,      32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
        vecs[3] = '{1'b1, ALUOP_ORI,   6'd0,      32'h0000_0010, 32'h0000_0001, 32'h0000_0011, 1'b0};
        vecs[4] = '{1'b0, ALUOP_RTYPE, FUNCT_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, ALUOP_RTYPE, FUNCT_OR,  32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0};

        reset = 1'b0;
        req_0 = 0; req_1 = 0; op_0 = 0; op_1 = 0; funct_0 = 0; funct_1 = 0;
        a_0 = 0; b_0 = 0; a_1 = 0; b_1 = 0; shamt_0 = 0; shamt_1 = 0;
        step(); step();

        // reset values
        chk_idle_outputs("rst");
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        reset = 1'b1;
        step();

        // tie after reset: port 0 first, then port 1
        drive_port(1'b0, ALUOP_ADDI, 6'd0, 32'd5, 32'd3);
        drive_port(1'b1, ALUOP_ORI, 6'd0, 32'h10, 32'h01);
        step();
        chk("tie_gnt0", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0;
        step();
        chk("tie_done0", {30'd0, done_1, done_0}, 32'd1);
        chk("tie_res0", result, 32'd8);
        step();
        chk("tie_gnt1", {30'd0, gnt_1, gnt_0}, 32'd2);
        req_1 = 1'b0;
        step();
        chk("tie_done1", {30'd0, done_1, done_0}, 32'd2);
        chk("tie_res1", result, 32'h11);
        step();
        chk_idle_outputs("tie_end");

        // fairness: both held for 8 ops
        drive_port(1'b0, ALUOP_ADDI, 6'd0, 32'd5, 32'd3);
        drive_port(1'b1, ALUOP_ORI, 6'd0, 32'h10, 32'h01);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("fair_busy", {31'd0, busy}, 32'd1);
            if (i % 2 == 0) begin
                chk("fair_gnt", {30'd0, gnt_1, gnt_0}, ((i / 2) % 2 == 0) ? 32'd1 : 32'd2);
                exp_q.push_back(((i / 2) % 2 == 0) ? 32'd8 : 32'h11);
            end else begin
                if (i == 15) begin
                    req_0 = 1'b0;
                    req_1 = 1'b0;
                end
                chk("fair_done", {30'd0, done_1, done_0}, ((i / 2) % 2 == 0) ? 32'd1 : 32'd2);
                if (exp_q.size() == 0) begin
                    chk("fair_queue_empty", 32'd1, 32'd0);
                end else begin
                    chk("fair_result", result, exp_q.pop_front());
                end
            end
        end
        step();
        chk_idle_outputs("fair_end");

        // table of single-port operations
        foreach (vecs[i]) begin
            drive_port(vecs[i].port, vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
            step();
            chk("vec_gnt", {30'd0, gnt_1, gnt_0}, vecs[i].port ? 32'd2 : 32'd1);
            chk("vec_alu_a", alu_a, vecs[i].a);
            chk("vec_alu_b", alu_b, vecs[i].b);
            chk("vec_alu_op", {29'd0, alu_op}, {29'd0, vecs[i].op});
            req_0 = 1'b0; req_1 = 1'b0;
            step();
            chk("vec_done", {30'd0, done_1, done_0}, vecs[i].port ? 32'd2 : 32'd1);
            chk("vec_result", result, vecs[i].exp_res);
            chk("vec_zero", {31'd0, zero}, {31'd0, vecs[i].exp_zero});
            step();
            chk_idle_outputs("vec_after");
            chk("vec_hold_result", result, vecs[i].exp_res);
            chk("vec_hold_alu_a", alu_a, vecs[i].a);
        end

        // reset during EXEC of a port-0 op, then a tie must go to port 0
        drive_port(1'b0, ALUOP_ADDI, 6'd0, 32'd7, 32'd7);
        step();
        chk("rmid_gnt0", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0;
        reset = 1'b0;
        step();
        chk_idle_outputs("rmid");
        chk("rmid_result", result, 32'd0);
        chk("rmid_zero", {31'd0, zero}, 32'd0);
        chk("rmid_alu_a", alu_a, 32'd0);
        reset = 1'b1;
        drive_port(1'b0, ALUOP_ADDI, 6'd0, 32'd1, 32'd2);
        drive_port(1'b1, ALUOP_ORI, 6'd0, 32'hF0, 32'h0F);
        step();
        chk("rmid_tie_gnt0", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0; req_1 = 1'b0;
        step();
        chk("rmid_tie_done0", {30'd0, done_1, done_0}, 32'd1);
        chk("rmid_tie_res", result, 32'd3);
        step();
        chk_idle_outputs("rmid_end");

        // req_1 pulses only during EXEC: ignored
        drive_port(1'b0, ALUOP_RTYPE, FUNCT_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
        step();
        chk("wd_gnt0", {30'd0, gnt_1, gnt_0}, 32'd1);
        req_0 = 1'b0;
        drive_port(1'b1, ALUOP_ORI, 6'd0, 32'h1, 32'h2);
        step();
        req_1 = 1'b0;
        chk("wd_done0", {30'd0, done_1, done_0}, 32'd1);
        chk("wd_result", result, 32'h0F0F_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outputs("wd_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // gnt and done must never name both ports at once
    always @(negedge clk) begin
        if (reset && ((gnt_0 && gnt_1) || (done_0 && done_1))) begin
            total++;
            bad++;
            $display("FAIL both_ports: gnt=%b%b done=%b%b expected at most one", gnt_1, gnt_0, done_1, done_0);
        end
    end

endmodule
